chu_gpo_chaser: RTL and testbench

Parametrised general-purpose output slot for the SoC MMIO bus, successor to the plain latched-output slot. Adds atomic set/clear/toggle writes, register readback, and a hardware LED chaser that steps a one-hot light across the port at a programmable rate without CPU involvement. It sits in one bus slot and drives the board LEDs directly.

---
 rtl/chu_gpo_chaser_if.sv | 13 +
 rtl/chu_gpo_chaser.sv | 154 +++++++++++++++
 tb/tb_chu_gpo_chaser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/chu_gpo_chaser_if.sv
// MMIO slot bus for chu_gpo_chaser: select, strobes, word address and data.
// The master drives requests; the slave returns combinational read data.
interface chu_gpo_chaser_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_gpo_chaser.sv
// General-purpose output slot with atomic set/clear/toggle writes, readback,
// and a one-hot LED chaser that steps at a programmable prescaled rate.
module chu_gpo_chaser #(
    parameter int W  = 16,
    parameter int CW = 24
) (
    input  logic              clk,
    input  logic              reset,
    chu_gpo_chaser_if.slave   bus,
    output logic [W-1:0]      dout
);
    localparam int            PW      = 5;
    localparam logic [PW-1:0] POS_MAX = PW'(W - 1);
    localparam logic [W-1:0]  ONE     = W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   buf_q;
    logic           bounce_q;
    logic [CW-1:0]  rate_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic           dir_q, dir_d;

    logic           wr_en, ctrl_wr, rate_wr, tick, bounce_eff, chase_en;
    logic [PW:0]    step_nxt;
    logic [31:0]    rd_mux;

    // Returns {dir, pos} after one chaser step; dir 1 means moving down.
    function automatic logic [PW:0] chase_step(input logic [PW-1:0] pos,
                                               input logic dir,
                                               input logic bounce);
        logic [PW-1:0] p;
        logic          d;
        p = pos;
        d = dir;
        if (!bounce) begin
            d = 1'b0;
            p = (pos == POS_MAX) ? PW'(0) : pos + PW'(1);
        end else if (!dir) begin
            if (pos == POS_MAX) begin
                d = 1'b1;
                p = POS_MAX - PW'(1);
            end else begin
                p = pos + PW'(1);
            end
        end else begin
            if (pos == PW'(0)) begin
                d = 1'b0;
                p = PW'(1);
            end else begin
                p = pos - PW'(1);
            end
        end
        return {d, p};
    endfunction

    assign wr_en      = bus.cs && bus.write;
    assign ctrl_wr    = wr_en && (bus.addr == 5'd4);
    assign rate_wr    = wr_en && (bus.addr == 5'd5);
    assign chase_en   = (state_q == RUN);
    assign tick       = chase_en && (cnt_q == rate_q);
    // A CTRL write landing on a tick cycle selects the mode used by that tick.
    assign bounce_eff = ctrl_wr ? bus.wr_data[1] : bounce_q;
    assign step_nxt   = chase_step(pos_q, dir_q, bounce_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q    <= '0;
            bounce_q <= 1'b0;
            rate_q   <= '0;
        end else if (wr_en) begin
            case (bus.addr)
                5'd0: buf_q    <= bus.wr_data[W-1:0];
                5'd1: buf_q    <= buf_q | bus.wr_data[W-1:0];
                5'd2: buf_q    <= buf_q & ~bus.wr_data[W-1:0];
                5'd3: buf_q    <= buf_q ^ bus.wr_data[W-1:0];
                5'd4: bounce_q <= bus.wr_data[1];
                5'd5: rate_q   <= bus.wr_data[CW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    // Restart sources (enable, RATE write) take priority over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pos_d = '0;
                dir_d = 1'b0;
                if (ctrl_wr && bus.wr_data[0]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ctrl_wr && !bus.wr_data[0]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pos_d   = '0;
                    dir_d   = 1'b0;
                end else if (rate_wr) begin
                    cnt_d = '0;
                end else if (tick) begin
                    cnt_d = '0;
                    pos_d = step_nxt[PW-1:0];
                    dir_d = step_nxt[PW];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (bus.cs) begin
            case (bus.addr)
                5'd0: rd_mux[W-1:0]  = buf_q;
                5'd4: rd_mux[1:0]    = {bounce_q, chase_en};
                5'd5: rd_mux[CW-1:0] = rate_q;
                5'd6: begin
                    rd_mux[PW-1:0] = pos_q;
                    rd_mux[8]      = dir_q;
                end
                default: rd_mux = '0;
            endcase
        end
    end

    assign bus.rd_data = rd_mux;
    assign dout        = chase_en ? (ONE << pos_q) : buf_q;

endmodule

// File: tb/tb_chu_gpo_chaser.sv
// Scoreboard bench for chu_gpo_chaser: stimulus queues expected dout/rd_data
// per checked cycle; a negedge monitor pops and compares.
module tb_chu_gpo_chaser;
    localparam int W  = 16;
    localparam int CW = 24;

    typedef struct {
        string       name;
        logic [31:0] exp_dout;
        bit          rd;
        logic [31:0] exp_rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  dout;
    logic          chk = 1'b0;
    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];

    chu_gpo_chaser_if bus ();

    chu_gpo_chaser #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: monitor sampled with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if ({16'h0, dout} !== e.exp_dout) begin
                    errors++;
                    $display("FAIL %s dout: got 0x%08h, expected 0x%08h", e.name, dout, e.exp_dout);
                end
                if (e.rd) begin
                    checks++;
                    if (bus.rd_data !== e.exp_rd) begin
                        errors++;
                        $display("FAIL %s rd_data: got 0x%08h, expected 0x%08h", e.name, bus.rd_data, e.exp_rd);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = 5'd0; bus.wr_data = 32'h0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        step();
        bus_idle();
    endtask

    task automatic chk_dout(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.exp_dout = exp; e.rd = 1'b0; e.exp_rd = 32'h0;
        sb.push_back(e);
        chk = 1'b1;
        step();
        chk = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [4:0] a,
                          input logic [31:0] exp_rd, input logic [31:0] exp_dout);
        exp_t e;
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        e.name = name; e.exp_dout = exp_dout; e.rd = 1'b1; e.exp_rd = exp_rd;
        sb.push_back(e);
        chk = 1'b1;
        step();
        chk = 1'b0;
        bus_idle();
    endtask

    initial begin
        reset = 1'b0;
        bus_idle();
        repeat (3) step();
        chk_dout("rst_dout", 32'h0);
        chk_rd("rst_status_in_reset", 5'd6, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        chk_rd("rst_data", 5'd0, 32'h0, 32'h0);
        chk_rd("rst_ctrl", 5'd4, 32'h0, 32'h0);
        chk_rd("rst_rate", 5'd5, 32'h0, 32'h0);
        chk_rd("rst_status", 5'd6, 32'h0, 32'h0);

        wr(5'd0, 32'h0000_A5A5);
        chk_dout("data_dout", 32'hA5A5);
        chk_rd("data_read", 5'd0, 32'h0000_A5A5, 32'hA5A5);
        wr(5'd1, 32'h0000_000F);
        chk_dout("set", 32'hA5AF);
        chk_rd("set_reads0", 5'd1, 32'h0, 32'hA5AF);
        wr(5'd2, 32'h0000_00A0);
        chk_dout("clr", 32'hA50F);
        wr(5'd3, 32'h0000_FFFF);
        chk_rd("tog", 5'd0, 32'h0000_5AF0, 32'h5AF0);

        // Wrap chase at rate 3: each position is held for 4 cycles.
        wr(5'd5, 32'd3);
        wr(5'd4, 32'd1);
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0)
                    chk_rd($sformatf("wrap_status_p%0d", p), 5'd6, 32'(p), 32'(1) << p);
                else
                    chk_dout($sformatf("wrap_p%0d_k%0d", p, k), 32'(1) << p);
            end
        end
        for (int k = 0; k < 4; k++) chk_dout($sformatf("wrap_back_k%0d", k), 32'h0001);

        wr(5'd0, 32'h0000_1234);
        chk_dout("data_while_chase", 32'h0002);
        wr(5'd4, 32'd0);
        chk_dout("chase_off_buf", 32'h1234);
        chk_rd("chase_off_ctrl", 5'd4, 32'h0, 32'h1234);

        // Bounce at rate 0: one step per cycle, up then down then up again.
        wr(5'd5, 32'd0);
        wr(5'd4, 32'd3);
        for (int i = 0; i < 33; i++) begin
            int p; int d;
            if (i < 16)      begin p = i;      d = 0; end
            else if (i < 31) begin p = 30 - i; d = 1; end
            else             begin p = i - 30; d = 0; end
            chk_rd($sformatf("bounce_i%0d", i), 5'd6, 32'(p) | (32'(d) << 8), 32'(1) << p);
        end

        // Bounce cleared on a tick cycle: that tick wraps 3 -> 4; RATE write then restarts the prescaler.
        wr(5'd4, 32'd1);
        wr(5'd5, 32'd9);
        chk_rd("rate9_ctrl", 5'd4, 32'h1, 32'h0010);
        for (int k = 1; k < 10; k++) chk_dout($sformatf("rate9_hold_k%0d", k), 32'h0010);
        chk_dout("rate9_step", 32'h0020);
        chk_rd("rate9_rate", 5'd5, 32'd9, 32'h0020);

        // Enable while cnt == rate: starts at pos 0 with no immediate step.
        wr(5'd4, 32'd0);
        wr(5'd5, 32'd0);
        wr(5'd4, 32'd1);
        chk_rd("enable_pos0", 5'd6, 32'h0, 32'h0001);
        chk_dout("enable_step1", 32'h0002);
        repeat (4) step();
        chk_dout("pre_reset_pos6", 32'h0040);

        reset = 1'b0;
        chk_dout("midreset_dout", 32'h0);
        chk_rd("midreset_status", 5'd6, 32'h0, 32'h0);
        reset = 1'b1;
        chk_rd("post_data", 5'd0, 32'h0, 32'h0);
        chk_rd("post_ctrl", 5'd4, 32'h0, 32'h0);
        chk_rd("post_rate", 5'd5, 32'h0, 32'h0);
        chk_rd("post_status", 5'd6, 32'h0, 32'h0);
        repeat (3) chk_dout("post_no_motion", 32'h0);

        wr(5'd9, 32'hFFFF_FFFF);
        wr(5'd7, 32'hFFFF_FFFF);
        chk_dout("badaddr_dout", 32'h0);
        chk_rd("badaddr_read9", 5'd9, 32'h0, 32'h0);
        chk_rd("badaddr_data", 5'd0, 32'h0, 32'h0);
        chk_rd("badaddr_ctrl", 5'd4, 32'h0, 32'h0);

        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
